operand_bypass_unit: RTL and testbench

//  Parametrised operand forwarding and hazard unit for the 5-stage MIPS core. It replaces the per-operand
//  E-stage forward muxes with one block that forwards NUM_RD source operands from M, W and a
//  one-cycle W-shadow register, detects load-use hazards, and freezes the pipe while data SRAM is busy.

---
 rtl/operand_bypass_unit_pkg.sv | 17 +
 rtl/operand_bypass_unit_mux.sv | 41 ++++
 rtl/operand_bypass_unit.sv | 161 ++++++++++++++++
 tb/tb_operand_bypass_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_bypass_unit_pkg.sv
// Shared constants for the operand bypass unit: forward-select codes and FSM states.
package operand_bypass_unit_pkg;

  localparam int DATALENGTH = 32;
  localparam logic [DATALENGTH-1:0] ZEROWORD = '0;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_SH = 2'b11;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } bypassState_t;

endpackage

// File: rtl/operand_bypass_unit_mux.sv
// Single-port priority forward select: M beats W beats shadow beats register file.
module bypass_mux
  import operand_bypass_unit_pkg::*;
#(
  parameter int DATA_W = DATALENGTH,
  parameter int AW     = 5
) (
  input  logic [AW-1:0]     srcAddr,
  input  logic [DATA_W-1:0] rfData,
  input  logic              wrEnM,
  input  logic [AW-1:0]     wrAddrM,
  input  logic [DATA_W-1:0] aluOutM,
  input  logic              wrEnW,
  input  logic [AW-1:0]     wrAddrW,
  input  logic [DATA_W-1:0] resultW,
  input  logic              shValid,
  input  logic [AW-1:0]     shAddr,
  input  logic [DATA_W-1:0] shData,
  output logic [DATA_W-1:0] opOut,
  output logic [1:0]        selOut
);

  always_comb begin
    opOut  = rfData;
    selOut = FWD_RF;
    // r0 always reads as the register-file value, never a forwarded one
    if (srcAddr != '0) begin
      if (wrEnM && (wrAddrM == srcAddr)) begin
        opOut  = aluOutM;
        selOut = FWD_M;
      end else if (wrEnW && (wrAddrW == srcAddr)) begin
        opOut  = resultW;
        selOut = FWD_W;
      end else if (shValid && (shAddr == srcAddr)) begin
        opOut  = shData;
        selOut = FWD_SH;
      end
    end
  end

endmodule

// File: rtl/operand_bypass_unit.sv
// Operand forwarding, load-use and SRAM-wait hazard control for the 5-stage core.
module operand_bypass_unit
  import operand_bypass_unit_pkg::*;
#(
  parameter int DATA_W   = DATALENGTH,
  parameter int AW       = 5,
  parameter int NUM_RD   = 2,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     src_addr_d,
  input  logic [NUM_RD-1:0]        src_used_d,
  input  logic [NUM_RD*AW-1:0]     src_addr_e,
  input  logic [NUM_RD*DATA_W-1:0] rf_data_e,
  input  logic                     wr_en_e,
  input  logic [AW-1:0]            wr_addr_e,
  input  logic                     mem_to_reg_e,
  input  logic                     wr_en_m,
  input  logic [AW-1:0]            wr_addr_m,
  input  logic [DATA_W-1:0]        alu_out_m,
  input  logic                     wr_en_w,
  input  logic [AW-1:0]            wr_addr_w,
  input  logic [DATA_W-1:0]        result_w,
  input  logic                     mem_req_m,
  input  logic                     mem_ready,
  output logic [NUM_RD*DATA_W-1:0] op_e,
  output logic [NUM_RD*2-1:0]      fwd_sel_e,
  output logic                     stall_f,
  output logic                     stall_d,
  output logic                     stall_e,
  output logic                     stall_m,
  output logic                     flush_e,
  output logic                     mem_timeout,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  bypassState_t      stateReg, stateNext;
  logic              shValidReg;
  logic [AW-1:0]     shAddrReg;
  logic [DATA_W-1:0] shDataReg;
  logic [WAIT_W-1:0] waitCntReg, waitCntNext;
  logic [CNT_W-1:0]  stallCntReg;
  logic              timeoutReg;

  logic              memStallStart;
  logic              loadUseHit;
  logic              stallAll;
  logic              loadUseStall;
  logic              stallDInt;
  logic              captureEn;
  logic [NUM_RD-1:0] portHit;

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
      logic [DATA_W-1:0] muxOp;
      logic [1:0]        muxSel;

      bypass_mux #(.DATA_W(DATA_W), .AW(AW)) u_mux (
        .srcAddr (src_addr_e[gi*AW +: AW]),
        .rfData  (rf_data_e[gi*DATA_W +: DATA_W]),
        .wrEnM   (wr_en_m),
        .wrAddrM (wr_addr_m),
        .aluOutM (alu_out_m),
        .wrEnW   (wr_en_w),
        .wrAddrW (wr_addr_w),
        .resultW (result_w),
        .shValid (shValidReg),
        .shAddr  (shAddrReg),
        .shData  (shDataReg),
        .opOut   (muxOp),
        .selOut  (muxSel)
      );

      // Outputs read as zero / rf-select for as long as reset is held
      assign op_e[gi*DATA_W +: DATA_W] = reset ? muxOp : DATA_W'(ZEROWORD);
      assign fwd_sel_e[gi*2 +: 2]      = reset ? muxSel : FWD_RF;
      assign portHit[gi] = src_used_d[gi] && (src_addr_d[gi*AW +: AW] == wr_addr_e);
    end
  endgenerate

  assign memStallStart = (stateReg == RUN) && mem_req_m && !mem_ready;
  assign loadUseHit    = mem_to_reg_e && wr_en_e && (wr_addr_e != '0) && (|portHit);

  always_comb begin
    stateNext    = stateReg;
    stallAll     = 1'b0;
    loadUseStall = 1'b0;
    case (stateReg)
      RUN: begin
        if (memStallStart) begin
          stateNext = MEM_WAIT;
          stallAll  = 1'b1;
        end else if (loadUseHit) begin
          loadUseStall = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          stateNext = RUN;
        end else begin
          stallAll = 1'b1;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    waitCntNext = waitCntReg;
    if (stateReg == MEM_WAIT) begin
      if (mem_ready) begin
        waitCntNext = '0;
      end else if (waitCntReg != WAIT_W'(WAIT_MAX)) begin
        waitCntNext = waitCntReg + WAIT_W'(1);
      end
    end
  end

  assign stallDInt = stallAll || loadUseStall;
  assign captureEn = (stateReg == RUN) && !memStallStart;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateReg    <= RUN;
      shValidReg  <= 1'b0;
      shAddrReg   <= '0;
      shDataReg   <= '0;
      waitCntReg  <= '0;
      stallCntReg <= '0;
      timeoutReg  <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
      // Shadow bridges the cycle where W writes the regfile and E already read the old value
      if (captureEn) begin
        shValidReg <= wr_en_w && (wr_addr_w != '0);
        shAddrReg  <= wr_addr_w;
        shDataReg  <= result_w;
      end
      if ((stateReg == MEM_WAIT) && !mem_ready && (waitCntNext == WAIT_W'(WAIT_MAX))) begin
        timeoutReg <= 1'b1;
      end
      if (stallDInt && (stallCntReg != '1)) begin
        stallCntReg <= stallCntReg + CNT_W'(1);
      end
    end
  end

  assign stall_f     = reset && stallDInt;
  assign stall_d     = reset && stallDInt;
  assign stall_e     = reset && stallAll;
  assign stall_m     = reset && stallAll;
  assign flush_e     = reset && loadUseStall;
  assign mem_timeout = timeoutReg;
  assign stall_cnt   = stallCntReg;

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Scoreboard bench: per-cycle expected outputs from a behavioural model, checked by a separate monitor.
module tb_operand_bypass_unit;

  localparam int DATA_W   = 32;
  localparam int AW       = 5;
  localparam int NUM_RD   = 2;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_RD*AW-1:0]     src_addr_d = '0;
  logic [NUM_RD-1:0]        src_used_d = '0;
  logic [NUM_RD*AW-1:0]     src_addr_e = '0;
  logic [NUM_RD*DATA_W-1:0] rf_data_e = '0;
  logic                     wr_en_e = 1'b0;
  logic [AW-1:0]            wr_addr_e = '0;
  logic                     mem_to_reg_e = 1'b0;
  logic                     wr_en_m = 1'b0;
  logic [AW-1:0]            wr_addr_m = '0;
  logic [DATA_W-1:0]        alu_out_m = '0;
  logic                     wr_en_w = 1'b0;
  logic [AW-1:0]            wr_addr_w = '0;
  logic [DATA_W-1:0]        result_w = '0;
  logic                     mem_req_m = 1'b0;
  logic                     mem_ready = 1'b0;
  logic [NUM_RD*DATA_W-1:0] op_e;
  logic [NUM_RD*2-1:0]      fwd_sel_e;
  logic                     stall_f, stall_d, stall_e, stall_m, flush_e;
  logic                     mem_timeout;
  logic [CNT_W-1:0]         stall_cnt;

  always #5 clock = ~clock;

  operand_bypass_unit #(
    .DATA_W(DATA_W), .AW(AW), .NUM_RD(NUM_RD), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .src_addr_d(src_addr_d), .src_used_d(src_used_d),
    .src_addr_e(src_addr_e), .rf_data_e(rf_data_e),
    .wr_en_e(wr_en_e), .wr_addr_e(wr_addr_e), .mem_to_reg_e(mem_to_reg_e),
    .wr_en_m(wr_en_m), .wr_addr_m(wr_addr_m), .alu_out_m(alu_out_m),
    .wr_en_w(wr_en_w), .wr_addr_w(wr_addr_w), .result_w(result_w),
    .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .op_e(op_e), .fwd_sel_e(fwd_sel_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_e(flush_e), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  typedef struct {
    int                       txn;
    logic [NUM_RD*DATA_W-1:0] op;
    logic [NUM_RD*2-1:0]      sel;
    logic [4:0]               ctl;   // {stall_f, stall_d, stall_e, stall_m, flush_e}
    logic                     tmo;
    logic [CNT_W-1:0]         cnt;
  } expItem_t;

  expItem_t expQ[$];
  int checks = 0;
  int errors = 0;
  int txnNum = 0;

  // Model state (current) and the state it moves to at the next rising edge
  bit          mInWait, pInWait;
  int          mWait,   pWait;
  bit          mTmo,    pTmo;
  int          mCnt,    pCnt;
  bit          mShV,    pShV;
  int          mShA,    pShA;
  logic [31:0] mShD,    pShD;

  task automatic modelReset();
    mInWait = 0; mWait = 0; mTmo = 0; mCnt = 0; mShV = 0; mShA = 0; mShD = '0;
    pInWait = 0; pWait = 0; pTmo = 0; pCnt = 0; pShV = 0; pShA = 0; pShD = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    mInWait = pInWait; mWait = pWait; mTmo = pTmo; mCnt = pCnt;
    mShV = pShV; mShA = pShA; mShD = pShD;
  endtask

  task automatic forwardOne(input int port, output logic [DATA_W-1:0] d, output logic [1:0] s);
    int a;
    a = int'(src_addr_e[port*AW +: AW]);
    d = rf_data_e[port*DATA_W +: DATA_W];
    s = 2'b00;
    if (a != 0) begin
      if (wr_en_m && int'(wr_addr_m) == a) begin d = alu_out_m; s = 2'b10; end
      else if (wr_en_w && int'(wr_addr_w) == a) begin d = result_w; s = 2'b01; end
      else if (mShV && mShA == a) begin d = mShD; s = 2'b11; end
    end
  endtask

  // Build the expectation for the inputs now applied, and the model's next state
  task automatic evaluate();
    expItem_t e;
    logic [DATA_W-1:0] d;
    logic [1:0] s;
    bit memStart, lu, all, luEff;
    e.txn = txnNum;
    txnNum++;
    if (!reset) begin
      modelReset();
      e.op = '0; e.sel = '0; e.ctl = '0; e.tmo = 1'b0; e.cnt = '0;
      expQ.push_back(e);
      return;
    end
    for (int i = 0; i < NUM_RD; i++) begin
      forwardOne(i, d, s);
      e.op[i*DATA_W +: DATA_W] = d;
      e.sel[i*2 +: 2] = s;
    end
    memStart = !mInWait && mem_req_m && !mem_ready;
    lu = 0;
    for (int i = 0; i < NUM_RD; i++)
      if (src_used_d[i] && src_addr_d[i*AW +: AW] == wr_addr_e) lu = 1;
    lu = lu && mem_to_reg_e && wr_en_e && (wr_addr_e != 0);
    all = 0; luEff = 0;
    if (mInWait) all = !mem_ready;
    else if (memStart) all = 1;
    else if (lu) luEff = 1;
    e.ctl = {all | luEff, all | luEff, all, all, luEff};
    e.tmo = mTmo;
    e.cnt = CNT_W'(mCnt);
    expQ.push_back(e);

    pInWait = mInWait; pWait = mWait; pTmo = mTmo;
    if (mInWait) begin
      if (mem_ready) begin pInWait = 0; pWait = 0; end
      else begin
        if (mWait < WAIT_MAX) pWait = mWait + 1;
        if (pWait == WAIT_MAX) pTmo = 1;
      end
    end else if (memStart) pInWait = 1;
    pCnt = ((all | luEff) && mCnt < CNT_MAX) ? mCnt + 1 : mCnt;
    pShV = mShV; pShA = mShA; pShD = mShD;
    if (!mInWait && !memStart) begin
      pShV = wr_en_w && (wr_addr_w != 0);
      pShA = int'(wr_addr_w);
      pShD = result_w;
    end
  endtask

  task automatic clearInputs();
    src_addr_d = '0; src_used_d = '0; src_addr_e = '0; rf_data_e = '0;
    wr_en_e = 0; wr_addr_e = '0; mem_to_reg_e = 0;
    wr_en_m = 0; wr_addr_m = '0; alu_out_m = '0;
    wr_en_w = 0; wr_addr_w = '0; result_w = '0;
    mem_req_m = 0; mem_ready = 0;
  endtask

  task automatic randInputs();
    for (int i = 0; i < NUM_RD; i++) begin
      src_addr_d[i*AW +: AW] = AW'($urandom_range(0, 3));
      src_addr_e[i*AW +: AW] = AW'($urandom_range(0, 3));
      rf_data_e[i*DATA_W +: DATA_W] = $urandom;
    end
    src_used_d   = NUM_RD'($urandom);
    wr_en_e      = 1'($urandom);
    wr_addr_e    = AW'($urandom_range(0, 3));
    mem_to_reg_e = 1'($urandom);
    wr_en_m      = 1'($urandom);
    wr_addr_m    = AW'($urandom_range(0, 3));
    alu_out_m    = $urandom;
    wr_en_w      = 1'($urandom);
    wr_addr_w    = AW'($urandom_range(0, 3));
    result_w     = $urandom;
    mem_req_m    = ($urandom_range(0, 4) == 0);
    mem_ready    = ($urandom_range(0, 2) != 0);
  endtask

  // Monitor: every cycle the DUT presents a fresh set of outputs
  initial begin
    expItem_t e;
    bit bad;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        bad = 0;
        checks++;
        if (op_e !== e.op) begin
          errors++; bad = 1;
          $display("FAIL op_e txn=%0d got=%h want=%h", e.txn, op_e, e.op);
        end
        checks++;
        if (fwd_sel_e !== e.sel) begin
          errors++; bad = 1;
          $display("FAIL fwd_sel_e txn=%0d got=%b want=%b", e.txn, fwd_sel_e, e.sel);
        end
        checks++;
        if ({stall_f, stall_d, stall_e, stall_m, flush_e} !== e.ctl) begin
          errors++; bad = 1;
          $display("FAIL stall_flush txn=%0d got=%b want=%b", e.txn,
                   {stall_f, stall_d, stall_e, stall_m, flush_e}, e.ctl);
        end
        checks++;
        if (mem_timeout !== e.tmo) begin
          errors++; bad = 1;
          $display("FAIL mem_timeout txn=%0d got=%b want=%b", e.txn, mem_timeout, e.tmo);
        end
        checks++;
        if (stall_cnt !== e.cnt) begin
          errors++; bad = 1;
          $display("FAIL stall_cnt txn=%0d got=%0d want=%0d", e.txn, stall_cnt, e.cnt);
        end
        $display("txn %0d: op=%h sel=%b ctl=%b tmo=%b cnt=%0d %s", e.txn, op_e, fwd_sel_e,
                 {stall_f, stall_d, stall_e, stall_m, flush_e}, mem_timeout, stall_cnt,
                 bad ? "bad" : "ok");
      end
    end
  end

  initial begin
    modelReset();
    #1 reset = 1'b0;
    // Reset held with random activity: everything must read zero
    for (int n = 0; n < 3; n++) begin tick(); randInputs(); evaluate(); end
    tick(); reset = 1'b1; clearInputs(); evaluate();

    // M hit
    tick(); clearInputs();
    wr_en_m = 1; wr_addr_m = 5'd8; alu_out_m = 32'h11; src_addr_e[0 +: AW] = 5'd8; evaluate();
    // M and W to the same register: M wins
    tick(); clearInputs();
    wr_en_m = 1; wr_addr_m = 5'd9; alu_out_m = 32'hA; wr_en_w = 1; wr_addr_w = 5'd9; result_w = 32'hB;
    src_addr_e[0 +: AW] = 5'd9; src_addr_e[AW +: AW] = 5'd9; evaluate();
    // r0 is never forwarded
    tick(); clearInputs();
    wr_en_m = 1; wr_addr_m = 5'd0; alu_out_m = 32'hDEAD; rf_data_e[DATA_W +: DATA_W] = 32'h77; evaluate();
    // Shadow: W writes r3, next cycle E reads r3
    tick(); clearInputs(); wr_en_w = 1; wr_addr_w = 5'd3; result_w = 32'h55; evaluate();
    tick(); clearInputs(); src_addr_e[0 +: AW] = 5'd3; evaluate();
    // Load-use on port 1
    tick(); clearInputs();
    mem_to_reg_e = 1; wr_en_e = 1; wr_addr_e = 5'd4; src_used_d = 2'b10; src_addr_d[AW +: AW] = 5'd4; evaluate();
    tick(); clearInputs(); evaluate();
    // SRAM wait for three cycles with a concurrent load-use, then ready
    for (int n = 0; n < 3; n++) begin
      tick(); clearInputs(); mem_req_m = 1; mem_ready = 0;
      mem_to_reg_e = 1; wr_en_e = 1; wr_addr_e = 5'd4; src_used_d = 2'b01; src_addr_d[0 +: AW] = 5'd4;
      evaluate();
    end
    tick(); clearInputs(); mem_req_m = 1; mem_ready = 1; evaluate();
    tick(); clearInputs(); evaluate();

    for (int n = 0; n < 2000; n++) begin tick(); randInputs(); evaluate(); end

    // Long SRAM wait crosses the timeout threshold
    tick(); clearInputs(); mem_ready = 1; evaluate();
    for (int n = 0; n < 20; n++) begin tick(); clearInputs(); mem_req_m = 1; evaluate(); end
    // Async reset mid-wait: outputs drop in the same cycle
    tick(); clearInputs(); mem_req_m = 1; reset = 1'b0; evaluate();
    tick(); clearInputs(); mem_req_m = 1; evaluate();
    tick(); reset = 1'b1; clearInputs(); evaluate();

    for (int n = 0; n < 400; n++) begin tick(); randInputs(); evaluate(); end

    @(negedge clock);
    #1;
    if (expQ.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain pending=%0d want=0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
